// File: rtl/branch_redirect_pc_unit.sv
// Fetch-side PC/nPC pair with delayed-branch redirects, stall buffering and IF status outputs.
// Optional branch-likely delay-slot annul is enabled by defining BRANCH_LIKELY_ANNUL_EN.
module branch_redirect_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic             redirect_taken,
    input  logic [31:0]      redirect_target,
    input  logic             redirect_annul,
    output logic             redirect_ready,
    output logic [31:0]      pc_out,
    output logic [31:0]      npc_out,
    output logic             fetch_valid,
    output logic             ds_annul,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        advance;
    logic        annul_in;
    logic        apply_taken;
    logic        apply_annul;
    logic [31:0] apply_target;
    logic        pend_taken;
    logic        pend_annul;
    logic [31:0] pend_target;

`ifdef BRANCH_LIKELY_ANNUL_EN
    assign annul_in = redirect_annul;
`else
    logic unused_annul;
    assign unused_annul = redirect_annul;
    assign annul_in     = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Select the decision applied on an advancing edge: buffered one in PEND, live one otherwise.
    always_comb begin
        redirect_ready = (state != PEND);
        accept         = redirect_valid & redirect_ready;
        advance        = (state != BOOT) & ~stall;
        fetch_valid    = (state != BOOT);
        apply_taken    = accept & redirect_taken;
        apply_annul    = accept & ~redirect_taken & annul_in;
        apply_target   = redirect_target;
        if (state == PEND) begin
            apply_taken  = pend_taken;
            apply_annul  = pend_annul;
            apply_target = pend_target;
        end
    end

    // A redirect accepted during BOOT cannot be applied (the PC does not move yet), so it is parked.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = accept ? PEND : RUN;
            RUN:     if (stall && accept) state_nxt = PEND;
            PEND:    if (!stall) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out      <= RESET_PC;
            npc_out     <= RESET_PC + 32'd4;
            ds_annul    <= 1'b0;
            pend_taken  <= 1'b0;
            pend_annul  <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            if (advance) begin
                pc_out   <= npc_out;
                npc_out  <= apply_taken ? {apply_target[31:2], 2'b00} : npc_out + 32'd4;
                ds_annul <= apply_annul;
            end
            if (accept && (stall || state == BOOT)) begin
                pend_taken  <= redirect_taken;
                pend_annul  <= annul_in;
                pend_target <= redirect_target;
            end else if (state == PEND && !stall) begin
                pend_taken  <= 1'b0;
                pend_annul  <= 1'b0;
                pend_target <= 32'h0;
            end
        end
    end

    // Statistics count at acceptance, whether the decision is applied now or later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_err <= 1'b0;
            taken_count  <= '0;
        end else if (accept && redirect_taken) begin
            taken_count <= sat_inc(taken_count);
            if (redirect_target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_pc_unit.sv
// Directed bench for branch_redirect_pc_unit (counter narrowed to 2 bits to reach saturation).
module tb_branch_redirect_pc_unit;

    localparam int CNT_W = 2;
`ifdef BRANCH_LIKELY_ANNUL_EN
    localparam logic EXP_ANNUL = 1'b1;
`else
    localparam logic EXP_ANNUL = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic             stall;
    logic             redirect_valid;
    logic             redirect_taken;
    logic [31:0]      redirect_target;
    logic             redirect_annul;
    logic             redirect_ready;
    logic [31:0]      pc_out;
    logic [31:0]      npc_out;
    logic             fetch_valid;
    logic             ds_annul;
    logic             misalign_err;
    logic [CNT_W-1:0] taken_count;

    int n_vec;
    int n_fail;

    branch_redirect_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_taken(redirect_taken),
        .redirect_target(redirect_target),
        .redirect_annul(redirect_annul),
        .redirect_ready(redirect_ready),
        .pc_out(pc_out),
        .npc_out(npc_out),
        .fetch_valid(fetch_valid),
        .ds_annul(ds_annul),
        .misalign_err(misalign_err),
        .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] pc, input logic [31:0] npc);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".npc"}, npc_out, npc);
    endtask

    task automatic redir(input logic tk, input logic [31:0] tgt, input logic an);
        redirect_valid  = 1'b1;
        redirect_taken  = tk;
        redirect_target = tgt;
        redirect_annul  = an;
    endtask

    task automatic idle();
        redirect_valid  = 1'b0;
        redirect_taken  = 1'b0;
        redirect_target = 32'hDEAD_BEEF;
        redirect_annul  = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        stall   = 1'b0;
        idle();
        tick();
        tick();
        chk_pc("reset", 32'h0, 32'h4);
        chk("reset.fv", {31'b0, fetch_valid}, 32'd0);
        chk("reset.ready", {31'b0, redirect_ready}, 32'd1);
        chk("reset.ds", {31'b0, ds_annul}, 32'd0);
        chk("reset.mis", {31'b0, misalign_err}, 32'd0);
        chk("reset.cnt", {30'b0, taken_count}, 32'd0);

        reset_n = 1'b1;
        chk("boot.fv", {31'b0, fetch_valid}, 32'd0);
        tick();
        chk_pc("run0", 32'h0, 32'h4);
        chk("run0.fv", {31'b0, fetch_valid}, 32'd1);
        tick();
        chk_pc("run1", 32'h4, 32'h8);
        tick();
        chk_pc("run2", 32'h8, 32'hC);

        redir(1'b1, 32'h100, 1'b0);
        tick();
        idle();
        chk_pc("br100.ds", 32'hC, 32'h100);
        chk("br100.cnt", {30'b0, taken_count}, 32'd1);
        tick();
        chk_pc("br100.tgt", 32'h100, 32'h104);
        tick();
        chk_pc("br100.seq", 32'h104, 32'h108);

        redir(1'b1, 32'h10, 1'b0);
        tick();
        idle();
        chk_pc("br10.ds", 32'h108, 32'h10);
        chk("br10.cnt", {30'b0, taken_count}, 32'd2);
        tick();
        chk_pc("br10.tgt", 32'h10, 32'h14);

        stall = 1'b1;
        redir(1'b1, 32'h200, 1'b0);
        chk("stall.ready0", {31'b0, redirect_ready}, 32'd1);
        tick();
        redir(1'b1, 32'h300, 1'b0);
        chk_pc("stall1", 32'h10, 32'h14);
        chk("stall1.ready", {31'b0, redirect_ready}, 32'd0);
        chk("stall1.cnt", {30'b0, taken_count}, 32'd3);
        tick();
        chk_pc("stall2", 32'h10, 32'h14);
        chk("stall2.ready", {31'b0, redirect_ready}, 32'd0);
        tick();
        chk_pc("stall3", 32'h10, 32'h14);
        chk("stall3.cnt", {30'b0, taken_count}, 32'd3);
        stall = 1'b0;
        idle();
        tick();
        chk_pc("release.ds", 32'h14, 32'h200);
        chk("release.ready", {31'b0, redirect_ready}, 32'd1);
        tick();
        chk_pc("release.tgt", 32'h200, 32'h204);

        redir(1'b1, 32'h103, 1'b0);
        tick();
        idle();
        chk_pc("mis.ds", 32'h204, 32'h100);
        chk("mis.flag", {31'b0, misalign_err}, 32'd1);
        chk("mis.sat", {30'b0, taken_count}, 32'd3);
        tick();
        chk_pc("mis.tgt", 32'h100, 32'h104);
        redir(1'b1, 32'h20, 1'b0);
        tick();
        idle();
        chk_pc("br20.ds", 32'h104, 32'h20);
        chk("mis.sticky", {31'b0, misalign_err}, 32'd1);
        tick();
        chk_pc("br20.tgt", 32'h20, 32'h24);
        chk("br20.ds_annul", {31'b0, ds_annul}, 32'd0);

        redir(1'b0, 32'h400, 1'b1);
        tick();
        idle();
        chk_pc("annul.slot", 32'h24, 32'h28);
        chk("annul.on", {31'b0, ds_annul}, {31'b0, EXP_ANNUL});
        chk("annul.cnt", {30'b0, taken_count}, 32'd3);
        tick();
        chk_pc("annul.next", 32'h28, 32'h2C);
        chk("annul.off", {31'b0, ds_annul}, 32'd0);

        redir(1'b1, 32'hFFFF_FFF8, 1'b0);
        tick();
        idle();
        chk_pc("wrap.ds", 32'h2C, 32'hFFFF_FFF8);
        tick();
        chk_pc("wrap.a", 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        tick();
        chk_pc("wrap.b", 32'hFFFF_FFFC, 32'h0);
        tick();
        chk_pc("wrap.c", 32'h0, 32'h4);
        tick();
        chk_pc("wrap.d", 32'h4, 32'h8);

        stall = 1'b1;
        redir(1'b1, 32'h500, 1'b0);
        tick();
        idle();
        chk("pend.ready", {31'b0, redirect_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_pc("pendrst", 32'h0, 32'h4);
        chk("pendrst.ready", {31'b0, redirect_ready}, 32'd1);
        chk("pendrst.fv", {31'b0, fetch_valid}, 32'd0);
        chk("pendrst.mis", {31'b0, misalign_err}, 32'd0);
        chk("pendrst.cnt", {30'b0, taken_count}, 32'd0);
        tick();
        reset_n = 1'b1;
        stall   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_pc("after_rst", 32'(4 * i), 32'(4 * i + 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
